// File: rtl/whisky_pkg.sv
// rtl/whisky_pkg.sv - shared constants and grant encoding for the writeback arbiter
package whisky_pkg;

  localparam int WHISKY_DATA_W = 16;
  localparam int WHISKY_SEL_W  = 3;
  localparam int WHISKY_NREG   = 8;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/whisky_rr_arb2.sv
// rtl/whisky_rr_arb2.sv - two-way round-robin arbiter remembering the last winner
module whisky_rr_arb2
  import whisky_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_grant_q, last_grant_d;

  always_comb begin
    gnt          = req;
    last_grant_d = last_grant_q;
    if (req == 2'b11) begin
      gnt = (last_grant_q == GNT_MEM) ? 2'b01 : 2'b10;
    end
    if (gnt[REQ_MEM]) begin
      last_grant_d = GNT_MEM;
    end else if (gnt[REQ_ALU]) begin
      last_grant_d = GNT_ALU;
    end
  end

  // Resetting to MEM lets the ALU win the first contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_MEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/whisky_wb_arbiter.sv
// rtl/whisky_wb_arbiter.sv - register file write port arbiter with pending scoreboard
// Optional forwarding hit outputs enabled by WHISKY_WB_BYPASS_EN.
module whisky_wb_arbiter
  import whisky_pkg::*;
#(
  parameter int DATA_W = WHISKY_DATA_W,
  parameter int SEL_W  = WHISKY_SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb0_valid,
  input  logic [SEL_W-1:0]  wb0_sel,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [SEL_W-1:0]  wb1_sel,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic              rsv_valid,
  input  logic [SEL_W-1:0]  rsv_sel,
  input  logic [SEL_W-1:0]  rd_sel_a,
  input  logic [SEL_W-1:0]  rd_sel_b,
  output logic              busy_a,
  output logic              busy_b,
`ifdef WHISKY_WB_BYPASS_EN
  output logic              hit_a,
  output logic              hit_b,
`endif
  output logic              rf_we,
  output logic [SEL_W-1:0]  rf_sel_w,
  output logic [DATA_W-1:0] rf_data
);

  localparam int NREG = 2**SEL_W;

  logic [1:0]        gnt;
  logic              granted;
  logic [SEL_W-1:0]  gnt_sel;
  logic [DATA_W-1:0] gnt_data;

  logic              rf_we_q, rf_we_d;
  logic [SEL_W-1:0]  rf_sel_w_q, rf_sel_w_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [NREG-1:0]   pending_q, pending_d;

  whisky_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({wb1_valid, wb0_valid}),
    .gnt   (gnt)
  );

  assign wb0_ready = gnt[REQ_ALU];
  assign wb1_ready = gnt[REQ_MEM];

  always_comb begin
    granted  = |gnt;
    gnt_sel  = gnt[REQ_MEM] ? wb1_sel  : wb0_sel;
    gnt_data = gnt[REQ_MEM] ? wb1_data : wb0_data;
  end

  // Register 0 is hardwired: its writebacks handshake but never assert the write enable.
  always_comb begin
    rf_we_d    = granted && (gnt_sel != '0);
    rf_sel_w_d = rf_sel_w_q;
    rf_data_d  = rf_data_q;
    if (granted) begin
      rf_sel_w_d = gnt_sel;
      rf_data_d  = gnt_data;
    end
  end

  // Clear is applied before set so a same-edge reservation keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) begin
      pending_d[rf_sel_w_q] = 1'b0;
    end
    if (rsv_valid) begin
      pending_d[rsv_sel] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_sel_w_q <= '0;
      rf_data_q  <= '0;
      pending_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_sel_w_q <= rf_sel_w_d;
      rf_data_q  <= rf_data_d;
      pending_q  <= pending_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_sel_w = rf_sel_w_q;
  assign rf_data  = rf_data_q;

`ifdef WHISKY_WB_BYPASS_EN
  assign hit_a  = rf_we_q && (rf_sel_w_q == rd_sel_a) && (rd_sel_a != '0);
  assign hit_b  = rf_we_q && (rf_sel_w_q == rd_sel_b) && (rd_sel_b != '0);
  assign busy_a = pending_q[rd_sel_a] && !hit_a;
  assign busy_b = pending_q[rd_sel_b] && !hit_b;
`else
  assign busy_a = pending_q[rd_sel_a];
  assign busy_b = pending_q[rd_sel_b];
`endif

endmodule

// File: tb/tb_whisky_wb_arbiter.sv
// tb/tb_whisky_wb_arbiter.sv - scoreboard bench for the writeback arbiter
module tb_whisky_wb_arbiter;
  import whisky_pkg::*;

  localparam int DW = WHISKY_DATA_W;
  localparam int SW = WHISKY_SEL_W;
  localparam int NR = WHISKY_NREG;
`ifdef WHISKY_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wb0_valid = 1'b0, wb1_valid = 1'b0;
  logic [SW-1:0] wb0_sel = '0, wb1_sel = '0;
  logic [DW-1:0] wb0_data = '0, wb1_data = '0;
  logic          wb0_ready, wb1_ready;
  logic          rsv_valid = 1'b0;
  logic [SW-1:0] rsv_sel = '0, rd_sel_a = '0, rd_sel_b = '0;
  logic          busy_a, busy_b;
  logic          rf_we;
  logic [SW-1:0] rf_sel_w;
  logic [DW-1:0] rf_data;
`ifdef WHISKY_WB_BYPASS_EN
  logic          hit_a, hit_b;
`endif

  always #5 clk = ~clk;

  whisky_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb0_valid (wb0_valid),
    .wb0_sel   (wb0_sel),
    .wb0_data  (wb0_data),
    .wb0_ready (wb0_ready),
    .wb1_valid (wb1_valid),
    .wb1_sel   (wb1_sel),
    .wb1_data  (wb1_data),
    .wb1_ready (wb1_ready),
    .rsv_valid (rsv_valid),
    .rsv_sel   (rsv_sel),
    .rd_sel_a  (rd_sel_a),
    .rd_sel_b  (rd_sel_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
`ifdef WHISKY_WB_BYPASS_EN
    .hit_a     (hit_a),
    .hit_b     (hit_b),
`endif
    .rf_we     (rf_we),
    .rf_sel_w  (rf_sel_w),
    .rf_data   (rf_data)
  );

  typedef struct {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  // Reference model: pending set, last winner, write occupying the current cycle.
  bit            pend_m[NR];
  int            last_m = REQ_MEM;
  bit            wr_now_v = 1'b0;
  logic [SW-1:0] wr_now_sel = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_hit(input logic [SW-1:0] s);
    return wr_now_v && (wr_now_sel == s) && (s != 0);
  endfunction

  function automatic bit model_busy(input logic [SW-1:0] s);
    if (s == 0) return 1'b0;
    return pend_m[s] && !(BYP && model_hit(s));
  endfunction

  // Monitor: every register-file write must match the head of the expected queue, in its cycle.
  bit due;
  always @(negedge clk) begin
    if (rst_n) begin
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("rf_we", rf_we, due);
      if (due) begin
        if (rf_we) begin
          chk("rf_sel_w", rf_sel_w, exp_q[0].sel);
          chk("rf_data", rf_data, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // One cycle: called at posedge+1 with inputs set; checks at negedge, advances the model.
  task automatic step();
    int            g;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
    @(negedge clk);
    g = -1;
    if (wb0_valid && wb1_valid) g = (last_m == REQ_ALU) ? REQ_MEM : REQ_ALU;
    else if (wb0_valid)         g = REQ_ALU;
    else if (wb1_valid)         g = REQ_MEM;
    chk("wb0_ready", wb0_ready, g == REQ_ALU);
    chk("wb1_ready", wb1_ready, g == REQ_MEM);
    chk("busy_a", busy_a, model_busy(rd_sel_a));
    chk("busy_b", busy_b, model_busy(rd_sel_b));
`ifdef WHISKY_WB_BYPASS_EN
    chk("hit_a", hit_a, model_hit(rd_sel_a));
    chk("hit_b", hit_b, model_hit(rd_sel_b));
`endif
    if (wr_now_v) pend_m[wr_now_sel] = 1'b0;
    if (rsv_valid && rsv_sel != 0) pend_m[rsv_sel] = 1'b1;
    wr_now_v = 1'b0;
    if (g >= 0) begin
      last_m = g;
      s = (g == REQ_ALU) ? wb0_sel : wb1_sel;
      d = (g == REQ_ALU) ? wb0_data : wb1_data;
      if (s != 0) begin
        exp_q.push_back('{sel: s, data: d, cyc: cyc + 1});
        wr_now_v   = 1'b1;
        wr_now_sel = s;
      end
    end
    @(posedge clk);
    #1;
    if (g == REQ_ALU) wb0_valid = 1'b0;
    if (g == REQ_MEM) wb1_valid = 1'b0;
    rsv_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rf_we_async", rf_we, 0);
    chk("rst_busy_a_async", busy_a, 0);
    chk("rst_busy_b_async", busy_b, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_sel_w", rf_sel_w, 0);
    chk("rst_rf_data", rf_data, 0);
    for (int i = 0; i < NR; i++) pend_m[i] = 1'b0;
    last_m   = REQ_MEM;
    wr_now_v = 1'b0;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int idx, input logic [SW-1:0] s, input logic [DW-1:0] d);
    if (idx == REQ_ALU) begin
      wb0_valid = 1'b1; wb0_sel = s; wb0_data = d;
    end else begin
      wb1_valid = 1'b1; wb1_sel = s; wb1_data = d;
    end
  endtask

  task automatic reserve(input logic [SW-1:0] s);
    rsv_valid = 1'b1;
    rsv_sel   = s;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) pend_m[i] = 1'b0;
    @(posedge clk);
    #1;

    // Reset with an ALU request held through it.
    set_req(REQ_ALU, 3'd3, 16'h1357);
    do_reset();
    step();
    chk("first_rf_we", rf_we, 1);
    chk("first_rf_sel_w", rf_sel_w, 3);
    step();

    // Both requesters held: grants alternate starting with the ALU.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!wb0_valid) set_req(REQ_ALU, 3'd3, 16'h1111);
      if (!wb1_valid) set_req(REQ_MEM, 3'd5, 16'h2222);
      step();
    end
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    repeat (2) step();

    // Reservation of sel 4 and its load writeback.
    rd_sel_a = 3'd4;
    reserve(3'd4);
    step();
    set_req(REQ_MEM, 3'd4, 16'hBEEF);
    repeat (3) step();

    // Register 0 writeback and reservation.
    set_req(REQ_ALU, 3'd0, 16'hFFFF);
    step();
    rd_sel_a = 3'd0;
    reserve(3'd0);
    repeat (2) step();

    // Reserve colliding with the clear of the same register.
    rd_sel_a = 3'd2;
    reserve(3'd2);
    step();
    set_req(REQ_ALU, 3'd2, 16'h2A2A);
    step();
    reserve(3'd2);
    step();
    repeat (2) step();

    // Asynchronous reset while sel 6 is pending and a write is in flight.
    rd_sel_a = 3'd6;
    reserve(3'd6);
    set_req(REQ_ALU, 3'd1, 16'h0101);
    step();
    #1;
    chk("pre_rst_busy_a", busy_a, model_busy(3'd6));
    chk("pre_rst_rf_we", rf_we, wr_now_v);
    do_reset();
    step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if (!wb0_valid && ($urandom_range(0, 2) == 0))
        set_req(REQ_ALU, SW'($urandom_range(0, NR - 1)), DW'($urandom));
      if (!wb1_valid && ($urandom_range(0, 2) == 0))
        set_req(REQ_MEM, SW'($urandom_range(0, NR - 1)), DW'($urandom));
      if ($urandom_range(0, 3) == 0) reserve(SW'($urandom_range(0, NR - 1)));
      rd_sel_a = SW'($urandom_range(0, NR - 1));
      rd_sel_b = SW'($urandom_range(0, NR - 1));
      step();
    end

    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    repeat (3) step();
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/whisky_wb_arbiter.md
Name: whisky_wb_arbiter

Overview:
- Sequences the single write port of the 8x16 register file (we, sel_w, data_in).
- Shares that write port between two writeback requesters using valid/ready handshakes and round-robin arbitration: requester 0 is the ALU, requester 1 is the memory load unit.
- Keeps a per-register pending scoreboard so the issue stage can detect read-after-write hazards on read ports A and B.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 16, register data width.
- SEL_W, 3, register select width; number of registers NREG = 2**SEL_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb0_valid  in  1  ALU writeback request.
- wb0_sel  in  SEL_W  ALU destination register.
- wb0_data  in  DATA_W  ALU result.
- wb0_ready  out  1  ALU request accepted this cycle.
- wb1_valid  in  1  memory writeback request.
- wb1_sel  in  SEL_W  memory destination register.
- wb1_data  in  DATA_W  load data.
- wb1_ready  out  1  memory request accepted this cycle.
- rsv_valid  in  1  issue stage reserves a destination register.
- rsv_sel  in  SEL_W  register being reserved.
- rd_sel_a  in  SEL_W  issue-stage read select, port A.
- rd_sel_b  in  SEL_W  issue-stage read select, port B.
- busy_a  out  1  port A source register is pending.
- busy_b  out  1  port B source register is pending.
- rf_we  out  1  register file write enable (registered).
- rf_sel_w  out  SEL_W  register file write select (registered).
- rf_data  out  DATA_W  register file write data (registered).

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_sel_w=0, rf_data=0, pending mask=0, last_grant=1 (so requester 0 wins first); outputs busy_a=busy_b=0.
- Arbitration (combinational ready):
  - Only one valid → that requester gets ready=1.
  - Both valid → grant the requester that did not win the previous grant; last_grant updates only on a grant.
  - No internal stall; the output register accepts every cycle. At most one ready is high per cycle.
  - A request is consumed when valid&&ready. Requesters hold valid/sel/data stable until ready.
- Output stage: on a grant, the next cycle drives rf_we=1, rf_sel_w=sel, rf_data=data. With no grant, rf_we=0; rf_sel_w/rf_data hold their values. Latency: grant at cycle N → rf_we high in N+1; the register file is written at the end of N+1.
- Register 0:
  - A writeback to sel 0 completes its handshake and is not dropped from arbitration.
  - rf_we stays 0 for it.
  - pending[0] is never set; busy for sel 0 is always 0.
- Scoreboard:
  - rsv_valid sets pending[rsv_sel] at the clock edge.
  - pending[rf_sel_w] clears at the edge ending a cycle with rf_we=1.
  - Reserve and clear of the same register in one edge → reserve wins; the bit stays 1.
  - Reserving an already-pending register keeps it 1 (no count, single outstanding write per register).
- Hazard outputs: busy_a = pending[rd_sel_a], busy_b = pending[rd_sel_b], combinational, with the register 0 rule applied.
- Reset mid-operation: in-flight requests are lost; requesters must re-present after reset.

Optional Feature:
- Macro WHISKY_WB_BYPASS_EN.
- Defined:
  - Adds outputs hit_a and hit_b (1 bit each). hit_x = rf_we && rf_sel_w==rd_sel_x && rd_sel_x!=0.
  - busy_x is forced low when hit_x is 1, so the issue stage forwards rf_data instead of stalling. This saves one cycle per dependency.
- Undefined: no hit ports; busy stays high through the rf_we cycle, as specified in Behaviour.

Decomposition:
- Package whisky_pkg holds:
  - constants WHISKY_DATA_W=16, WHISKY_SEL_W=3, WHISKY_NREG=8;
  - localparams REQ_ALU=0, REQ_MEM=1 for grant encoding.
- One natural sub-module, whisky_rr_arb2: a 2-way round-robin arbiter holding last_grant, with inputs req[1:0] and output gnt[1:0].
- Scoreboard and output register stay in the top module.

Test Plan:
- Reset with wb0_valid=1 held → rf_we=0 and busy_a=busy_b=0 during reset; first cycle after release wb0_ready=1, then rf_we=1 and rf_sel_w=wb0_sel the next cycle.
- wb0 (sel 3, 0x1111) and wb1 (sel 5, 0x2222) both held valid for 4 cycles → grants alternate 0,1,0,1; rf writes are sel 3, 5, 3, 5 with matching data.
- rsv_valid sel 4, then wb1 sel 4 data 0xBEEF granted at cycle N:
  - rd_sel_a=4: busy_a=1 through cycle N+1 and 0 at N+2.
  - With WHISKY_WB_BYPASS_EN: busy_a=0 and hit_a=1 at N+1.
- wb0 to sel 0, data 0xFFFF → wb0_ready=1, rf_we stays 0; rsv_valid sel 0 → busy_a stays 0 with rd_sel_a=0.
- rsv_valid sel 2 in the same edge that clears pending[2] (rf_we=1, rf_sel_w=2) → busy on sel 2 remains 1 afterwards.
- rsv_valid sel 6, then rst_n pulsed low asynchronously mid-cycle → pending cleared and rf_we=0 immediately, without waiting for a clock edge.
